operand_seq_4b: RTL and testbench

Sequencing front end for the 4-bit bitwise logic units (xor_4b and its siblings). It accepts operands one nibble at a time over a valid/ready handshake and holds A and B stable on the logic unit's inputs. It captures the unit's combinational result Y and returns it over a second valid/ready handshake. It is the synchronous stage directly upstream and downstream of the combinational 4-bit logic block.

---
 rtl/logic4_pkg.sv | 13 +
 rtl/operand_seq_4b_nibble_reg.sv | 26 ++
 rtl/operand_seq_4b.sv | 122 ++++++++++++
 tb/tb_operand_seq_4b.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/logic4_pkg.sv
// Shared types and constants for the 4-bit logic unit sequencing front end.
package logic4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/operand_seq_4b_nibble_reg.sv
// Load-enabled register with synchronous reset to zero, used for operands and the result.
module nibble_reg
    import logic4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/operand_seq_4b.sv
// Operand sequencer: collects A then B, holds them for the logic unit, returns Y.
// Optional res_parity output is enabled by defining OPERAND_SEQ_PARITY_EN.
module operand_seq_4b
    import logic4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] y_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
`ifdef OPERAND_SEQ_PARITY_EN
    ,
    output logic             res_parity
`endif
);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [CNT_W-1:0] op_count_reg;
    logic             in_fire;
    logic             res_fire;
    logic             res_load;
    logic [1:0]       opnd_load;
    logic [WIDTH-1:0] opnd_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake strobes; the ready/valid outputs themselves depend on state alone.
    always_comb begin
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        state_next = state_reg;
        case (state_reg)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) state_next = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_next = LOAD_A;
            end
            default: state_next = LOAD_A;
        endcase
    end

    assign in_fire      = in_valid && in_ready;
    assign res_fire     = res_valid && res_ready;
    assign res_load     = (state_reg == EXEC);
    assign opnd_load[0] = in_fire && (state_reg == LOAD_A);
    assign opnd_load[1] = in_fire && (state_reg == LOAD_B);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            nibble_reg #(.WIDTH(WIDTH)) u_opnd_reg (
                .clk  (clk),
                .rst  (rst),
                .load (opnd_load[gi]),
                .d    (in_data),
                .q    (opnd_q[gi])
            );
        end
    endgenerate

    assign a_out = opnd_q[0];
    assign b_out = opnd_q[1];

    nibble_reg #(.WIDTH(WIDTH)) u_res_reg (
        .clk  (clk),
        .rst  (rst),
        .load (res_load),
        .d    (y_in),
        .q    (res_data)
    );

`ifdef OPERAND_SEQ_PARITY_EN
    nibble_reg #(.WIDTH(1)) u_parity_reg (
        .clk  (clk),
        .rst  (rst),
        .load (res_load),
        .d    (^y_in),
        .q    (res_parity)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_reg <= '0;
        end else if (res_fire) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign op_count = op_count_reg;

endmodule

// File: tb/tb_operand_seq_4b.sv
// Self-checking bench for operand_seq_4b, with an XOR unit closing the loop on y_in.
module tb_operand_seq_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] y_in;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       busy;
    logic [7:0] op_count;
`ifdef OPERAND_SEQ_PARITY_EN
    logic       res_parity;
`endif

    operand_seq_4b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .a_out     (a_out),
        .b_out     (b_out),
        .y_in      (y_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .op_count  (op_count)
`ifdef OPERAND_SEQ_PARITY_EN
        ,
        .res_parity(res_parity)
`endif
    );

    always #5 clk = ~clk;

    // xor_4b stand-in
    assign y_in = a_out ^ b_out;

    int         errors = 0;
    int         checks = 0;
    int         model_cnt = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        int         hold;
        bit         stray;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a result handshake completes on the edge following this negedge.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("sb_res_data", int'(res_data), int'(e));
                $display("result handshake: res_data=%h expected=%h", res_data, e);
            end
            model_cnt = (model_cnt + 1) % 256;
        end
    end

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] y,
                         input int hold, input bit stray);
        wait_in_ready();
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        @(posedge clk); #1;
        chk("a_out_after_accept", int'(a_out), int'(a));
        chk("in_ready_load_b", int'(in_ready), 1);
        in_data = b;
        exp_q.push_back(y);
        @(posedge clk); #1;
        chk("b_out_after_accept", int'(b_out), int'(b));
        chk("exec_busy", int'(busy), 1);
        chk("exec_in_ready", int'(in_ready), 0);
        chk("exec_res_valid", int'(res_valid), 0);
        if (stray) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
        end else begin
            in_valid = 1'b0;
        end
        res_ready = (hold == 0);
        @(posedge clk); #1;
        chk("res_valid_latency", int'(res_valid), 1);
        chk("res_data_latency", int'(res_data), int'(y));
`ifdef OPERAND_SEQ_PARITY_EN
        chk("res_parity", int'(res_parity), int'(^y));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_data", int'(res_data), int'(y));
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_a_out", int'(a_out), int'(a));
            chk("bp_b_out", int'(b_out), int'(b));
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_res_valid", int'(res_valid), 0);
        chk("post_op_count", int'(op_count), model_cnt);
        chk("post_a_hold", int'(a_out), int'(a));
        chk("post_b_hold", int'(b_out), int'(b));
        chk("post_res_hold", int'(res_data), int'(y));
        $display("op A=%b B=%b hold=%0d stray=%0d -> res_data=%b op_count=%0d",
                 a, b, hold, stray, res_data, op_count);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{a: 4'b1100, b: 4'b1010, y: 4'b0110, hold: 0, stray: 1'b0};
        vecs[1] = '{a: 4'b0011, b: 4'b0101, y: 4'b0110, hold: 5, stray: 1'b0};
        vecs[2] = '{a: 4'b1001, b: 4'b0110, y: 4'b1111, hold: 2, stray: 1'b1};
        vecs[3] = '{a: 4'b0001, b: 4'b0011, y: 4'b0010, hold: 0, stray: 1'b1};
        vecs[4] = '{a: 4'b0000, b: 4'b0000, y: 4'b0000, hold: 1, stray: 1'b0};
        vecs[5] = '{a: 4'b1111, b: 4'b1111, y: 4'b0000, hold: 0, stray: 1'b0};
        vecs[6] = '{a: 4'b0111, b: 4'b1000, y: 4'b1111, hold: 3, stray: 1'b1};

        in_valid  = 1'b0;
        in_data   = 4'h0;
        res_ready = 1'b0;
        apply_reset();

        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_a_out", int'(a_out), 0);
        chk("rst_b_out", int'(b_out), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_op_count", int'(op_count), 0);
`ifdef OPERAND_SEQ_PARITY_EN
        chk("rst_res_parity", int'(res_parity), 0);
`endif

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].hold, vecs[i].stray);
        chk("count_after_table", int'(op_count), 7);

        // res_ready while idle must not count
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("stray_res_ready_count", int'(op_count), 7);
        chk("stray_res_ready_in_ready", int'(in_ready), 1);

        // Reset in LOAD_B abandons operand A
        in_valid = 1'b1;
        in_data  = 4'b0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midop_a_out", int'(a_out), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        chk("midop_rst_a_out", int'(a_out), 0);
        chk("midop_rst_in_ready", int'(in_ready), 1);
        chk("midop_rst_res_valid", int'(res_valid), 0);
        chk("midop_rst_busy", int'(busy), 0);
        chk("midop_rst_op_count", int'(op_count), 0);
        chk("midop_rst_res_data", int'(res_data), 0);

        // Wrap: 256 ops bring op_count back to zero
        for (int i = 0; i < 256; i++) do_op(4'b1111, 4'b0000, 4'b1111, 0, 1'b0);
        chk("wrap_op_count", int'(op_count), 0);
        chk("wrap_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
